// File: rtl/audio_sample_frontend_pkg.sv
// Shared types and helpers for the audio ingest front end: FSM state encoding,
// accumulator width derivation and saturating absolute value.
package audio_sample_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic int acc_width(input int in_w, input int ch, input int decim_log2);
    return in_w + $clog2(ch) + decim_log2;
  endfunction

  // |x| for a w-bit signed value held sign-extended in 32 bits; the most
  // negative w-bit value maps to the largest positive one.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (w - 1));
    if (x == most_neg) return (32'd1 << (w - 1)) - 32'd1;
    else if (x < 0)    return $unsigned(-x);
    else               return $unsigned(x);
  endfunction

endpackage

// File: rtl/audio_sample_frontend_level_meter.sv
// Peak-hold level meter with linear decay: loads the louder of the accepted
// sample level and the decayed meter, and steps down by one per decay tick.
module level_meter
  import audio_sample_frontend_pkg::*;
#(
  parameter int OUT_WIDTH   = 16,
  parameter int METER_WIDTH = 10,
  parameter int DECAY_LOG2  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OUT_WIDTH-1:0]   sample_i,
  input  logic                   accept_i,
  output logic [METER_WIDTH-1:0] meter_o
);

  localparam int TW = (DECAY_LOG2 > 0) ? DECAY_LOG2 : 1;

  logic [TW-1:0]          timer_q, timer_d;
  logic [METER_WIDTH-1:0] meter_q, meter_d;
  logic [METER_WIDTH-1:0] decayed, lvl;
  logic                   tick;

  always_comb begin
    lvl     = METER_WIDTH'(abs_sat(32'($signed(sample_i)), OUT_WIDTH) >> (OUT_WIDTH - 1 - METER_WIDTH));
    tick    = (DECAY_LOG2 == 0) ? 1'b1 : (timer_q == '1);
    timer_d = timer_q + 1'b1;
    decayed = (tick && meter_q != '0) ? meter_q - 1'b1 : meter_q;
    // Decay is applied first so a quieter sample cannot undo this cycle's step.
    meter_d = (accept_i && lvl > decayed) ? lvl : decayed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
      meter_q <= '0;
    end else begin
      timer_q <= timer_d;
      meter_q <= meter_d;
    end
  end

  assign meter_o = meter_q;

endmodule

// File: rtl/audio_sample_frontend.sv
// Codec-to-DFT ingest: reads a multi-channel sample, sums channels serially,
// averages 2^DECIM_LOG2 reads, trims to OUT_WIDTH and hands off via valid/ready.
module audio_sample_frontend
  import audio_sample_frontend_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int DECIM_LOG2  = 0,
  parameter int METER_WIDTH = 10,
  parameter int DECAY_LOG2  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sampleReady,
  input  logic [CHANNELS*IN_WIDTH-1:0] sampleIn,
  output logic                         doRead,
  output logic [OUT_WIDTH-1:0]         outSample,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [METER_WIDTH-1:0]       meter,
  output logic                         busy
);

  localparam int ACC_W = acc_width(IN_WIDTH, CHANNELS, DECIM_LOG2);
  localparam int SHIFT = $clog2(CHANNELS) + DECIM_LOG2;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = DECIM_LOG2 + 1;

  state_e                        state_q, state_d;
  logic [CHANNELS*IN_WIDTH-1:0]  cap_q, cap_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [OUT_WIDTH-1:0]          out_q, out_d;
  logic                          vld_q, vld_d;

  logic signed [IN_WIDTH-1:0]    chan;
  logic signed [ACC_W-1:0]       acc_sum;
  logic                          last_ch, last_read;

  always_comb begin
    chan = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (idx_q == IDX_W'(c)) chan = cap_q[c*IN_WIDTH +: IN_WIDTH];
    end
    acc_sum   = acc_q + ACC_W'(chan);
    last_ch   = (idx_q == IDX_W'(CHANNELS - 1));
    last_read = (cnt_q == CNT_W'((1 << DECIM_LOG2) - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sampleReady) state_d = SUM;
      SUM:     if (last_ch) state_d = last_read ? EMIT : IDLE;
      EMIT:    if (outReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_d = cap_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    out_d = out_q;
    vld_d = vld_q;
    case (state_q)
      IDLE: begin
        if (sampleReady) begin
          cap_d = sampleIn;
          idx_d = '0;
        end
      end
      SUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (last_ch) begin
          cnt_d = cnt_q + 1'b1;
          // Floor average then keep the top OUT_WIDTH bits of the IN_WIDTH result.
          if (last_read) begin
            out_d = OUT_WIDTH'(acc_sum >>> (SHIFT + IN_WIDTH - OUT_WIDTH));
            vld_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (outReady) begin
          vld_d = 1'b0;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // doRead is qualified by rst so a level-high sampleReady cannot ack during reset.
  always_comb begin
    doRead    = rst && (state_q == IDLE) && sampleReady;
    busy      = (state_q != IDLE);
    outValid  = vld_q;
    outSample = out_q;
  end

  level_meter #(
    .OUT_WIDTH  (OUT_WIDTH),
    .METER_WIDTH(METER_WIDTH),
    .DECAY_LOG2 (DECAY_LOG2)
  ) u_meter (
    .clk     (clk),
    .rst     (rst),
    .sample_i(out_q),
    .accept_i(vld_q && outReady),
    .meter_o (meter)
  );

endmodule

// File: tb/tb_audio_sample_frontend.sv
// Directed bench for audio_sample_frontend: instance A averages nothing, instance B
// averages four reads; a spec-level model checks every cycle of both.
`timescale 1ns/1ps
module tb_audio_sample_frontend;

  localparam int CH = 2, IW = 24, OW = 16, MW = 10, DL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sr_a = 1'b0, sr_b = 1'b0, ordy_a = 1'b1, ordy_b = 1'b1;
  logic [CH*IW-1:0] sin_a = '0, sin_b = '0;
  logic dr_a, dr_b, ov_a, ov_b, bz_a, bz_b;
  logic [OW-1:0] os_a, os_b;
  logic [MW-1:0] mt_a, mt_b;

  int n_vec = 0, n_fail = 0;
  int n_dr [2];
  longint m_sum [2];
  int m_rd [2], m_meter [2];
  bit m_pdr [2], m_hold [2], m_pv [2];
  logic [OW-1:0] m_hos [2], m_pend [2];
  int m_t;

  always #5 clk = ~clk;

  audio_sample_frontend #(.CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DECIM_LOG2(0),
                          .METER_WIDTH(MW), .DECAY_LOG2(DL)) u_a (
    .clk(clk), .rst(rst), .sampleReady(sr_a), .sampleIn(sin_a), .doRead(dr_a),
    .outSample(os_a), .outValid(ov_a), .outReady(ordy_a), .meter(mt_a), .busy(bz_a));

  audio_sample_frontend #(.CHANNELS(CH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DECIM_LOG2(2),
                          .METER_WIDTH(MW), .DECAY_LOG2(DL)) u_b (
    .clk(clk), .rst(rst), .sampleReady(sr_b), .sampleIn(sin_b), .doRead(dr_b),
    .outSample(os_b), .outValid(ov_b), .outReady(ordy_b), .meter(mt_b), .busy(bz_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Floor-average of all channel samples over 2^dlog reads, top OW bits of IW.
  function automatic logic [OW-1:0] exp_out(input longint s, input int dlog);
    longint avg;
    avg = s >>> ($clog2(CH) + dlog);
    return OW'(avg >>> (IW - OW));
  endfunction

  function automatic int lvl_of(input logic [OW-1:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > (1 << (OW - 1)) - 1) v = (1 << (OW - 1)) - 1;
    return v >>> (OW - 1 - MW);
  endfunction

  task automatic step(input int k, input int dlog, input logic dr, input logic ov,
                      input logic bz, input logic sr, input logic ordy,
                      input logic [OW-1:0] os, input logic [MW-1:0] mt,
                      input logic [CH*IW-1:0] sin);
    int dec, lv;
    bit acc;
    chk($sformatf("meter_track%0d", k), 64'(mt), 64'(m_meter[k]));
    if (ov) chk($sformatf("busy_in_emit%0d", k), 64'(bz), 64'd1);
    if (dr) begin
      n_dr[k]++;
      chk($sformatf("dr_back2back%0d", k), 64'(m_pdr[k]), 64'd0);
      chk($sformatf("dr_only_idle%0d", k), 64'({sr, ov, m_pv[k]}), 64'b100);
      for (int c = 0; c < CH; c++) m_sum[k] += longint'($signed(sin[c*IW +: IW]));
      m_rd[k]++;
      if (m_rd[k] == (1 << dlog)) begin
        m_pend[k] = exp_out(m_sum[k], dlog);
        m_pv[k]   = 1'b1;
        m_sum[k]  = 0;
        m_rd[k]   = 0;
      end
    end
    if (m_hold[k]) chk($sformatf("hold_stable%0d", k), 64'({ov, os}), 64'({1'b1, m_hos[k]}));
    acc = ov && ordy;
    lv  = 0;
    if (acc) begin
      chk($sformatf("out_pending%0d", k), 64'(m_pv[k]), 64'd1);
      chk($sformatf("out_sample%0d", k), 64'(os), 64'(m_pend[k]));
      lv = lvl_of(m_pend[k]);
      m_pv[k] = 1'b0;
    end
    m_hold[k] = ov && !ordy;
    m_hos[k]  = os;
    m_pdr[k]  = dr;
    dec = m_meter[k];
    if ((m_t % (1 << DL)) == (1 << DL) - 1 && dec > 0) dec--;
    m_meter[k] = (acc && lv > dec) ? lv : dec;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_sum[k] = 0; m_rd[k] = 0; m_meter[k] = 0;
        m_pdr[k] = 0; m_hold[k] = 0; m_pv[k] = 0;
      end
      m_t = 0;
    end else begin
      step(0, 0, dr_a, ov_a, bz_a, sr_a, ordy_a, os_a, mt_a, sin_a);
      step(1, 2, dr_b, ov_b, bz_b, sr_b, ordy_b, os_b, mt_b, sin_b);
      m_t++;
    end
  end

  function automatic logic sig(input int k, input int which);
    if (k == 0) return (which == 0) ? dr_a : ov_a;
    return (which == 0) ? dr_b : ov_b;
  endfunction

  // Returns at the negedge where the signal is seen; n counts negedges waited.
  task automatic wait_sig(input int k, input int which, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (sig(k, which)) begin
        n = i;
        return;
      end
      @(posedge clk); #1;
    end
    n_vec++; n_fail++;
    $display("FAIL wait_timeout inst%0d sig%0d: got none, required a pulse within 40 cycles", k, which);
  endtask

  task automatic do_read(input int k, input logic [IW-1:0] c0, input logic [IW-1:0] c1);
    int n;
    if (k == 0) begin sin_a = {c1, c0}; sr_a = 1'b1; end
    else        begin sin_b = {c1, c0}; sr_b = 1'b1; end
    wait_sig(k, 0, n);
    @(posedge clk); #1;
    if (k == 0) sr_a = 1'b0; else sr_b = 1'b0;
  endtask

  task automatic get_out(input int k, output logic [OW-1:0] v, output int lat);
    wait_sig(k, 1, lat);
    v = (k == 0) ? os_a : os_b;
    @(posedge clk); #1;
  endtask

  task automatic run_a(input logic [IW-1:0] c0, input logic [IW-1:0] c1,
                       input logic [OW-1:0] exp_s, input logic [MW-1:0] exp_m);
    logic [OW-1:0] v;
    int lat, d0;
    d0 = n_dr[0];
    do_read(0, c0, c1);
    get_out(0, v, lat);
    chk("latency_a", 64'(lat), 64'd3);
    chk("sample_a", 64'(v), 64'(exp_s));
    chk("one_doread_a", 64'(n_dr[0] - d0), 64'd1);
    @(negedge clk);
    chk("meter_a", 64'(mt_a), 64'(exp_m));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [OW-1:0] v;
    int lat, d0;
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] v;
    int lat, d0;
    sr_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_a", 64'({dr_a, ov_a, os_a, mt_a, bz_a}), 64'd0);
    chk("reset_outs_b", 64'({dr_b, ov_b, os_b, mt_b, bz_b}), 64'd0);
    @(posedge clk); #1;
    sr_a = 1'b0;
    rst  = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    run_a(24'h000100, 24'h000100, 16'h0001, 10'd0);
    run_a(24'hFFFF00, 24'hFFFF00, 16'hFFFF, 10'd0);
    run_a(24'h000001, 24'hFFFFFE, 16'hFFFF, 10'd0);
    run_a(24'h800000, 24'h800000, 16'h8000, 10'h3FF);

    repeat (39) @(posedge clk);
    @(negedge clk);
    chk("decay_40cyc", 64'(mt_a), 64'd1013);
    repeat (4100) @(posedge clk);
    @(negedge clk);
    chk("decay_floor", 64'(mt_a), 64'd0);
    @(posedge clk); #1;

    run_a(24'h800000, 24'h800000, 16'h8000, 10'h3FF);
    repeat (39) @(posedge clk);
    @(negedge clk);
    chk("decay_again", 64'(mt_a), 64'd1013);
    @(posedge clk); #1;
    run_a(24'h7FFF00, 24'h7FFF00, 16'h7FFF, 10'h3FF);

    ordy_a = 1'b0;
    do_read(0, 24'h123400, 24'h123400);
    sr_a = 1'b1;
    wait_sig(0, 1, lat);
    @(posedge clk); #1;
    d0 = n_dr[0];
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bp_held", 64'({ov_a, os_a}), 64'({1'b1, 16'h1234}));
    chk("bp_no_doread", 64'(n_dr[0] - d0), 64'd0);
    @(posedge clk); #1;
    ordy_a = 1'b1;
    @(negedge clk);
    chk("bp_accept_cycle", 64'({ov_a, dr_a}), 64'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_doread", 64'({ov_a, dr_a}), 64'b01);
    @(posedge clk); #1;
    sr_a = 1'b0;
    get_out(0, v, lat);
    chk("bp_second_sample", 64'(v), 64'h1234);

    sin_a = {24'h7FFF00, 24'h7FFF00};
    sr_a  = 1'b1;
    wait_sig(0, 0, lat);
    @(posedge clk); #1;
    sr_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("async_reset_a", 64'({dr_a, ov_a, os_a, mt_a, bz_a}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_a(24'h000100, 24'h000100, 16'h0001, 10'd0);

    d0 = n_dr[1];
    for (int r = 1; r <= 4; r++) begin
      do_read(1, IW'(r << 12), IW'(r << 12));
    end
    get_out(1, v, lat);
    chk("decim_sample_b", 64'(v), 64'h0028);
    chk("decim_reads_b", 64'(n_dr[1] - d0), 64'd4);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
